// File: rtl/plus_pkg.sv
// Shared types and the single-lane add/subtract/saturate function for the
// plus_sat_pipe datapath.
package plus_pkg;

   // Widest lane the arithmetic helper supports (lane WIDTH must be < MAX_W).
   localparam int MAX_W = 64;

   typedef logic signed [MAX_W-1:0] wide_t;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   typedef struct packed {
      logic  ovf;
      wide_t res;
   } sum_t;

   // Add or subtract two sign-extended w-bit operands.
   // The exact result needs w+1 bits, so shifting it right by w-1 leaves
   // 0 or -1 when it fits in w bits. Any other value is an overflow, and the
   // sign of the exact result picks the clamp direction.
   // Subtraction is a + ~b + 1, so both ops share one adder.
   function automatic sum_t sat_add(input wide_t a,
                                    input wide_t b,
                                    input op_e   op,
                                    input logic  sat,
                                    input int    w);
      wide_t bx;
      wide_t r;
      wide_t t;
      wide_t vmax;
      wide_t vmin;
      logic  cin;
      logic  o;
      sum_t  s;
      cin  = (op == OP_SUB);
      bx   = cin ? ~b : b;
      r    = a + bx + {{(MAX_W-1){1'b0}}, cin};
      t    = r >>> (w - 1);
      o    = (t != '0) && (t != '1);
      vmax = (wide_t'(1) << (w - 1)) - wide_t'(1);
      vmin = ~vmax;
      s.ovf = o;
      if (o && sat) begin
         s.res = r[MAX_W-1] ? vmin : vmax;
      end else begin
         s.res = r;
      end
      return s;
   endfunction

endpackage

// File: rtl/plus_lane.sv
// Combinational single-lane signed add/subtract with optional saturation.
// It returns the WIDTH-bit result and the lane overflow flag.
module plus_lane
   import plus_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic signed [WIDTH-1:0] i_a,
   input  logic signed [WIDTH-1:0] i_b,
   input  op_e                     i_op,
   output logic signed [WIDTH-1:0] o_res,
   output logic                    o_ovf
);

   sum_t w_sum;
   logic w_unused_hi;

   assign w_sum  = sat_add(wide_t'(i_a), wide_t'(i_b), i_op, SATURATE, WIDTH);
   assign o_res  = w_sum.res[WIDTH-1:0];
   assign o_ovf  = w_sum.ovf;

   // Only the low WIDTH bits matter. The rest are sign or clamp fill.
   assign w_unused_hi = ^w_sum.res[MAX_W-1:WIDTH];

endmodule

// File: rtl/plus_sat_pipe.sv
// Pipelined multi-lane signed adder/subtractor with per-lane overflow flags,
// a saturating overflow event counter and a valid/ready stream interface.
// Stage 1 holds the arithmetic result. Later stages only delay it.
// Every stage collapses bubbles, so the pipe holds up to STAGES beats.
module plus_sat_pipe
   import plus_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int LANES    = 1,
   parameter int STAGES   = 2,
   parameter bit SATURATE = 1'b1,
   parameter int CNT_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   op,
   input  logic [LANES*WIDTH-1:0] in_1,
   input  logic [LANES*WIDTH-1:0] in_2,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] out,
   output logic [LANES-1:0]       ovf,
   input  logic                   cnt_clr,
   output logic [CNT_W-1:0]       ovf_count
);

   localparam int DW = LANES * WIDTH;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [DW-1:0]    w_res;
   logic [LANES-1:0] w_ovf;

   logic [STAGES:1]  r_vld;
   logic [DW-1:0]    r_data [1:STAGES];
   logic [LANES-1:0] r_ovf  [1:STAGES];

   logic [STAGES:1]  w_ld;
   logic             w_chain;
   logic             w_out_xfer;

   logic [CNT_W-1:0] r_cnt;

   // ---- Stage 0 -> 1 boundary: per-lane arithmetic on the raw inputs ----
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      plus_lane #(
         .WIDTH    (WIDTH),
         .SATURATE (SATURATE)
      ) u_lane (
         .i_a   (in_1[l*WIDTH +: WIDTH]),
         .i_b   (in_2[l*WIDTH +: WIDTH]),
         .i_op  (op_e'(op)),
         .o_res (w_res[l*WIDTH +: WIDTH]),
         .o_ovf (w_ovf[l])
      );
   end

   // Ready chain: a stage may load when it is empty or its successor loads.
   // The chain starts from out_ready and never sees in_valid.
   always_comb begin
      w_ld    = '0;
      w_chain = !r_vld[STAGES] || out_ready;
      w_ld[STAGES] = w_chain;
      for (int k = STAGES - 1; k >= 1; k--) begin
         w_chain = !r_vld[k] || w_chain;
         w_ld[k] = w_chain;
      end
   end

   // No transfer is offered in either direction while reset is held.
   assign in_ready   = w_ld[1] && !rst;
   assign out_valid  = r_vld[STAGES] && !rst;
   assign out        = r_data[STAGES];
   assign ovf        = r_ovf[STAGES];
   assign w_out_xfer = out_valid && out_ready;

   // ---- Stage 1..STAGES registers: stage 1 captures results, later stages delay ----
   // Data only moves when a valid beat moves, so an emptied stage keeps its last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         for (int k = 1; k <= STAGES; k++) begin
            r_data[k] <= '0;
            r_ovf[k]  <= '0;
         end
      end else begin
         if (w_ld[1]) begin
            r_vld[1] <= in_valid;
            if (in_valid) begin
               r_data[1] <= w_res;
               r_ovf[1]  <= w_ovf;
            end
         end
         for (int k = 2; k <= STAGES; k++) begin
            if (w_ld[k]) begin
               r_vld[k] <= r_vld[k-1];
               if (r_vld[k-1]) begin
                  r_data[k] <= r_data[k-1];
                  r_ovf[k]  <= r_ovf[k-1];
               end
            end
         end
      end
   end

   // ---- Output boundary: count transferred beats that flagged any overflow ----
   // Clear takes priority over a coincident increment. The count holds at all-ones.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         r_cnt <= '0;
      end else if (w_out_xfer && (|r_ovf[STAGES]) && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign ovf_count = r_cnt;

endmodule

// File: tb/tb_plus_sat_pipe.sv
// Directed self-checking bench for plus_sat_pipe.
// u_dut : default parameters (saturating, 1 lane, 2 stages)
// u_wrap: SATURATE=0, driven by the same inputs as u_dut
// u_cnt4: CNT_W=4, driven by the same inputs as u_dut
// u_quad: LANES=4, driven by its own inputs
module tb_plus_sat_pipe;

   logic clk = 1'b0;
   logic rst;

   // Inputs shared by u_dut, u_wrap and u_cnt4.
   logic        in_valid;
   logic        op;
   logic        out_ready;
   logic        cnt_clr;
   logic [15:0] in_1;
   logic [15:0] in_2;

   logic        d_in_ready, d_out_valid;
   logic [15:0] d_out;
   logic [0:0]  d_ovf;
   logic [15:0] d_cnt;

   logic        w_in_ready, w_out_valid;
   logic [15:0] w_out;
   logic [0:0]  w_ovf;
   logic [15:0] w_cnt;

   logic        c_in_ready, c_out_valid;
   logic [15:0] c_out;
   logic [0:0]  c_ovf;
   logic [3:0]  c_cnt;

   // Inputs and outputs of the 4-lane instance.
   logic        q_in_valid, q_op, q_out_ready, q_cnt_clr;
   logic [63:0] q_in_1, q_in_2;
   logic        q_in_ready, q_out_valid;
   logic [63:0] q_out;
   logic [3:0]  q_ovf;
   logic [15:0] q_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   plus_sat_pipe u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready), .op(op),
      .in_1(in_1), .in_2(in_2), .out_valid(d_out_valid), .out_ready(out_ready),
      .out(d_out), .ovf(d_ovf), .cnt_clr(cnt_clr), .ovf_count(d_cnt)
   );

   plus_sat_pipe #(.SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .op(op),
      .in_1(in_1), .in_2(in_2), .out_valid(w_out_valid), .out_ready(out_ready),
      .out(w_out), .ovf(w_ovf), .cnt_clr(cnt_clr), .ovf_count(w_cnt)
   );

   plus_sat_pipe #(.CNT_W(4)) u_cnt4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .op(op),
      .in_1(in_1), .in_2(in_2), .out_valid(c_out_valid), .out_ready(out_ready),
      .out(c_out), .ovf(c_ovf), .cnt_clr(cnt_clr), .ovf_count(c_cnt)
   );

   plus_sat_pipe #(.LANES(4)) u_quad (
      .clk(clk), .rst(rst), .in_valid(q_in_valid), .in_ready(q_in_ready), .op(q_op),
      .in_1(q_in_1), .in_2(q_in_2), .out_valid(q_out_valid), .out_ready(q_out_ready),
      .out(q_out), .ovf(q_ovf), .cnt_clr(q_cnt_clr), .ovf_count(q_cnt)
   );

   // Advance one clock and settle just after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; op = 1'b0; in_1 = '0; in_2 = '0; out_ready = 1'b0; cnt_clr = 1'b0;
      q_in_valid = 1'b0; q_op = 1'b0; q_in_1 = '0; q_in_2 = '0; q_out_ready = 1'b0; q_cnt_clr = 1'b0;
      repeat (3) cyc();
      rst = 1'b0;
      #1;
      checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", d_out_valid); end
      checks++; if (d_out !== 16'h0000) begin errors++; $display("FAIL reset_out got %h want 0000", d_out); end
      checks++; if (d_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", d_ovf); end
      checks++; if (d_cnt !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", d_cnt); end
      checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", d_in_ready); end
      checks++; if (q_out_valid !== 1'b0 || q_in_ready !== 1'b1) begin errors++; $display("FAIL reset_quad got v=%b r=%b want v=0 r=1", q_out_valid, q_in_ready); end
      out_ready = 1'b1;
      q_out_ready = 1'b1;
   endtask

   task automatic test_add_sat();
      in_valid = 1'b1; op = 1'b0; in_1 = 16'h7FFF; in_2 = 16'h0001;
      cyc();
      in_valid = 1'b0;
      checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b want 0", d_out_valid); end
      cyc();
      checks++; if (d_out_valid !== 1'b1 || d_out !== 16'h7FFF || d_ovf !== 1'b1) begin
         errors++; $display("FAIL add_sat got v=%b out=%h ovf=%b want v=1 out=7fff ovf=1", d_out_valid, d_out, d_ovf);
      end
      checks++; if (w_out_valid !== 1'b1 || w_out !== 16'h8000 || w_ovf !== 1'b1) begin
         errors++; $display("FAIL add_wrap got v=%b out=%h ovf=%b want v=1 out=8000 ovf=1", w_out_valid, w_out, w_ovf);
      end
      cyc();
      checks++; if (d_cnt !== 16'd1 || w_cnt !== 16'd1) begin errors++; $display("FAIL add_count got %0d/%0d want 1/1", d_cnt, w_cnt); end
      checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL add_drained got %b want 0", d_out_valid); end
   endtask

   task automatic test_sub();
      logic [15:0] sa [3];
      logic [15:0] sb [3];
      logic [15:0] es [3];
      logic [15:0] ew [3];
      logic        eo [3];
      sa = '{16'h0000, 16'h8000, 16'h1234};
      sb = '{16'h8000, 16'h0001, 16'h0234};
      es = '{16'h7FFF, 16'h8000, 16'h1000};
      ew = '{16'h8000, 16'h7FFF, 16'h1000};
      eo = '{1'b1, 1'b1, 1'b0};
      op = 1'b1;
      for (int n = 0; n < 5; n++) begin
         if (n < 3) begin
            in_valid = 1'b1; in_1 = sa[n]; in_2 = sb[n];
         end else begin
            in_valid = 1'b0;
         end
         cyc();
         if (n >= 1 && n <= 3) begin
            checks++; if (d_out_valid !== 1'b1 || d_out !== es[n-1] || d_ovf !== eo[n-1]) begin
               errors++; $display("FAIL sub_sat[%0d] got v=%b out=%h ovf=%b want v=1 out=%h ovf=%b", n-1, d_out_valid, d_out, d_ovf, es[n-1], eo[n-1]);
            end
            checks++; if (w_out !== ew[n-1] || w_ovf !== eo[n-1]) begin
               errors++; $display("FAIL sub_wrap[%0d] got out=%h ovf=%b want out=%h ovf=%b", n-1, w_out, w_ovf, ew[n-1], eo[n-1]);
            end
         end
      end
      checks++; if (d_cnt !== 16'd3 || w_cnt !== 16'd3) begin errors++; $display("FAIL sub_count got %0d/%0d want 3/3", d_cnt, w_cnt); end
      checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL sub_drained got %b want 0", d_out_valid); end
      op = 1'b0;
   endtask

   task automatic test_back_to_back();
      int c;
      int tx;
      int rx;
      logic in_x;
      logic out_x;
      logic [15:0] exp_v;
      c = 0; tx = 0; rx = 0;
      op = 1'b0;
      while (rx < 10 && c < 40) begin
         out_ready = !(c >= 3 && c <= 7);
         in_valid  = (tx < 10);
         in_1      = 16'(tx) << 8;
         in_2      = 16'(tx);
         #1;
         checks++; if (d_in_ready !== out_ready) begin
            errors++; $display("FAIL stall_in_ready c=%0d got %b want %b", c, d_in_ready, out_ready);
         end
         if (d_out_valid) begin
            exp_v = 16'(rx * 257);
            checks++; if (d_out !== exp_v || d_ovf !== 1'b0) begin
               errors++; $display("FAIL stall_data c=%0d got out=%h ovf=%b want out=%h ovf=0", c, d_out, d_ovf, exp_v);
            end
         end
         in_x  = in_valid && d_in_ready;
         out_x = d_out_valid && out_ready;
         cyc();
         if (in_x) tx++;
         if (out_x) rx++;
         c++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++; if (rx != 10 || tx != 10) begin errors++; $display("FAIL stall_beats got rx=%0d tx=%0d want 10/10", rx, tx); end
      cyc();
      checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL stall_extra_beat got %b want 0", d_out_valid); end
      checks++; if (d_cnt !== 16'd3) begin errors++; $display("FAIL stall_count got %0d want 3", d_cnt); end
   endtask

   task automatic test_lanes();
      q_in_valid = 1'b1; q_op = 1'b0;
      q_in_1 = {16'hFFFE, 16'h4000, 16'h8000, 16'h1000};
      q_in_2 = {16'hFFFF, 16'h4000, 16'h0001, 16'hF000};
      cyc();
      q_op = 1'b1;
      q_in_1 = {16'hC000, 16'h8000, 16'h7000, 16'h0005};
      q_in_2 = {16'h4000, 16'h0001, 16'h1000, 16'h0007};
      cyc();
      q_in_valid = 1'b0;
      checks++; if (q_out_valid !== 1'b1 || q_out !== {16'hFFFD, 16'h7FFF, 16'h8001, 16'h0000} || q_ovf !== 4'b0100) begin
         errors++; $display("FAIL lanes_add got v=%b out=%h ovf=%b want v=1 out=fffd7fff80010000 ovf=0100", q_out_valid, q_out, q_ovf);
      end
      checks++; if (q_cnt !== 16'd0) begin errors++; $display("FAIL lanes_count0 got %0d want 0", q_cnt); end
      cyc();
      checks++; if (q_out_valid !== 1'b1 || q_out !== {16'h8000, 16'h8000, 16'h6000, 16'hFFFE} || q_ovf !== 4'b0100) begin
         errors++; $display("FAIL lanes_sub got v=%b out=%h ovf=%b want v=1 out=800080006000fffe ovf=0100", q_out_valid, q_out, q_ovf);
      end
      checks++; if (q_cnt !== 16'd1) begin errors++; $display("FAIL lanes_count1 got %0d want 1", q_cnt); end
      cyc();
      checks++; if (q_cnt !== 16'd2 || q_out_valid !== 1'b0) begin errors++; $display("FAIL lanes_count2 got cnt=%0d v=%b want 2/0", q_cnt, q_out_valid); end
   endtask

   task automatic test_cnt_sat();
      cnt_clr = 1'b1;
      cyc();
      cnt_clr = 1'b0;
      checks++; if (c_cnt !== 4'd0) begin errors++; $display("FAIL cnt_clear got %0d want 0", c_cnt); end
      op = 1'b0; in_1 = 16'h7FFF; in_2 = 16'h0001;
      in_valid = 1'b1;
      repeat (20) cyc();
      in_valid = 1'b0;
      repeat (3) cyc();
      checks++; if (c_cnt !== 4'd15) begin errors++; $display("FAIL cnt_saturate got %0d want 15", c_cnt); end
      checks++; if (d_cnt !== 16'd20) begin errors++; $display("FAIL cnt_wide got %0d want 20", d_cnt); end
      // Clear coincident with an overflowing output transfer.
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc();
      checks++; if (c_out_valid !== 1'b1 || c_ovf !== 1'b1) begin errors++; $display("FAIL cnt_pending got v=%b ovf=%b want 1/1", c_out_valid, c_ovf); end
      cnt_clr = 1'b1;
      cyc();
      cnt_clr = 1'b0;
      checks++; if (c_cnt !== 4'd0 || c_out_valid !== 1'b0) begin errors++; $display("FAIL cnt_clr_wins got cnt=%0d v=%b want 0/0", c_cnt, c_out_valid); end
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      repeat (2) cyc();
      checks++; if (c_cnt !== 4'd1) begin errors++; $display("FAIL cnt_after_clr got %0d want 1", c_cnt); end
   endtask

   task automatic test_midreset();
      out_ready = 1'b0;
      op = 1'b0;
      in_valid = 1'b1; in_1 = 16'h7FFF; in_2 = 16'h0001;
      cyc();
      in_1 = 16'h0100; in_2 = 16'h0001;
      cyc();
      in_valid = 1'b0;
      checks++; if (d_out_valid !== 1'b1 || d_in_ready !== 1'b0) begin
         errors++; $display("FAIL midrst_full got v=%b r=%b want 1/0", d_out_valid, d_in_ready);
      end
      rst = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_during got %b want 0", d_out_valid); end
      cyc();
      rst = 1'b0;
      #1;
      checks++; if (d_out_valid !== 1'b0 || d_cnt !== 16'd0 || d_out !== 16'h0000 || d_in_ready !== 1'b1) begin
         errors++; $display("FAIL midrst_after got v=%b cnt=%0d out=%h r=%b want 0/0/0000/1", d_out_valid, d_cnt, d_out, d_in_ready);
      end
      in_valid = 1'b1; in_1 = 16'h0200; in_2 = 16'h0003;
      cyc();
      in_valid = 1'b0;
      checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_early got %b want 0", d_out_valid); end
      cyc();
      checks++; if (d_out_valid !== 1'b1 || d_out !== 16'h0203 || d_ovf !== 1'b0) begin
         errors++; $display("FAIL midrst_next got v=%b out=%h ovf=%b want 1/0203/0", d_out_valid, d_out, d_ovf);
      end
      cyc();
      checks++; if (d_out_valid !== 1'b0 || d_cnt !== 16'd0) begin
         errors++; $display("FAIL midrst_no_stale got v=%b cnt=%0d want 0/0", d_out_valid, d_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_add_sat();
      test_sub();
      test_back_to_back();
      test_lanes();
      test_cnt_sat();
      test_midreset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
